// File: rtl/rgbw_pkg.sv
// ---------------------------------------------------------------------------
// rgbw_pkg
// Shared declarations for the RGBW frame decoder.
//   state_e           : frame FSM state encoding (2-bit)
//   DEFAULT_SYNC_BYTE : marker that opens every frame
//   clog2()           : ceiling log2, used to size the index and timeout counters
// ---------------------------------------------------------------------------
package rgbw_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_MODE    = 2'd2,
        ST_CSUM    = 2'd3
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

    // Number of bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rgbw_rdy_sync.sv
// ---------------------------------------------------------------------------
// rgbw_rdy_sync
// Brings the SPI byte-ready level into the clk domain and turns each rising
// edge into a single one-enabled-cycle strobe, with the matching byte.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   clk_half     : clock enable, state advances only when low
//   rx_rdy       : byte-ready level from the SPI slave (asynchronous)
//   rx_data      : received byte, stable while rx_rdy is high
//   strobe       : one enabled cycle per rx_rdy rising edge
//   byte_q       : byte belonging to the current strobe
// ---------------------------------------------------------------------------
module rgbw_rdy_sync #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_half,
    input  logic              rx_rdy,
    input  logic [DATA_W-1:0] rx_data,
    output logic              strobe,
    output logic [DATA_W-1:0] byte_q
);

    logic              s1_q;
    logic              s2_q;
    logic              strobe_q;
    logic [DATA_W-1:0] data_q;
    logic              edgeSeen;

    // Rising edge as seen after the two synchroniser flops.
    assign edgeSeen = s1_q & ~s2_q;

    // Synchroniser chain plus a registered strobe. The byte is taken on the
    // same edge that registers the strobe, while rx_rdy is known to be high,
    // so strobe and byte leave this block together from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            strobe_q <= 1'b0;
            data_q   <= '0;
        end else if (!clk_half) begin
            s1_q     <= rx_rdy;
            s2_q     <= s1_q;
            strobe_q <= edgeSeen;
            if (edgeSeen) begin
                data_q <= rx_data;
            end
        end
    end

    assign strobe = strobe_q;
    assign byte_q = data_q;

endmodule

// File: rtl/rgbw_frame_decoder.sv
// ---------------------------------------------------------------------------
// rgbw_frame_decoder
// Hunts for a sync byte, collects NUM_CH channel bytes, a mode byte and an
// optional checksum byte, and only then updates the channel bank atomically.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   clk_half     : clock enable, state advances only when low
//   rx_data      : received byte from the SPI slave
//   rx_rdy       : byte-ready level from the SPI slave
//   ch_out       : channel bank, channel 0 in the LSBs
//   mode_out     : mode byte of the last valid frame
//   frame_valid  : one-enabled-cycle pulse when the bank updates
//   frame_err    : one-enabled-cycle pulse on checksum failure or timeout
//   err_count    : saturating count of frame_err pulses
//   busy         : high while a frame is being collected
// ---------------------------------------------------------------------------
module rgbw_frame_decoder
    import rgbw_pkg::*;
#(
    parameter int                NUM_CH      = 6,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(DEFAULT_SYNC_BYTE),
    parameter bit                CHECKSUM_EN = 1'b1,
    parameter int                TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_half,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_rdy,
    output logic [NUM_CH*DATA_W-1:0] ch_out,
    output logic [DATA_W-1:0]        mode_out,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic [7:0]               err_count,
    output logic                     busy
);

    localparam int                IDX_W    = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);
    localparam int                TO_W     = clog2(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    logic              strobe;
    logic [DATA_W-1:0] rxByte;

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [DATA_W-1:0]               sum_q, sum_d;
    logic [DATA_W-1:0]               csumTotal;
    logic [TO_W-1:0]                 toCnt_q, toCnt_d;
    logic [NUM_CH-1:0][DATA_W-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0][DATA_W-1:0]   chOut_q, chOut_d;
    logic [DATA_W-1:0]               modeShadow_q, modeShadow_d;
    logic [DATA_W-1:0]               modeOut_q, modeOut_d;
    logic                            frameValid_q, frameValid_d;
    logic                            frameErr_q, frameErr_d;
    logic [7:0]                      errCount_q, errCount_d;

    rgbw_rdy_sync #(
        .DATA_W (DATA_W)
    ) u_rdy_sync (
        .clk      (clk),
        .reset    (reset),
        .clk_half (clk_half),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .strobe   (strobe),
        .byte_q   (rxByte)
    );

    // Frame FSM next-state logic. The timeout is only evaluated on cycles
    // without a strobe, so a byte arriving on the expiry cycle wins. The
    // shadow bank is copied to the outputs only on a complete, valid frame.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        toCnt_d      = toCnt_q;
        shadow_d     = shadow_q;
        chOut_d      = chOut_q;
        modeShadow_d = modeShadow_q;
        modeOut_d    = modeOut_q;
        frameValid_d = 1'b0;
        frameErr_d   = 1'b0;
        errCount_d   = errCount_q;
        csumTotal    = sum_q + rxByte;

        if (strobe) begin
            toCnt_d = '0;
        end else if (state_q != ST_HUNT) begin
            if (toCnt_q == TO_LAST) begin
                toCnt_d    = '0;
                state_d    = ST_HUNT;
                frameErr_d = 1'b1;
            end else begin
                toCnt_d = toCnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_HUNT: begin
                if (strobe && rxByte == SYNC_BYTE) begin
                    state_d = ST_PAYLOAD;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_PAYLOAD: begin
                if (strobe) begin
                    shadow_d[idx_q] = rxByte;
                    sum_d           = sum_q + rxByte;
                    idx_d           = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_MODE;
                    end
                end
            end
            ST_MODE: begin
                if (strobe) begin
                    modeShadow_d = rxByte;
                    sum_d        = sum_q + rxByte;
                    if (CHECKSUM_EN) begin
                        state_d = ST_CSUM;
                    end else begin
                        chOut_d      = shadow_q;
                        modeOut_d    = rxByte;
                        frameValid_d = 1'b1;
                        state_d      = ST_HUNT;
                    end
                end
            end
            ST_CSUM: begin
                if (strobe) begin
                    // Payload + mode + checksum must wrap to zero.
                    if (csumTotal == '0) begin
                        chOut_d      = shadow_q;
                        modeOut_d    = modeShadow_q;
                        frameValid_d = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                    state_d = ST_HUNT;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        if (frameErr_d && errCount_q != 8'hFF) begin
            errCount_d = errCount_q + 8'd1;
        end
    end

    // State register. Reset acts on every clk edge; everything else only
    // moves on enabled edges, which also stretches the pulses to exactly
    // one enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            idx_q        <= '0;
            sum_q        <= '0;
            toCnt_q      <= '0;
            shadow_q     <= '0;
            chOut_q      <= '0;
            modeShadow_q <= '0;
            modeOut_q    <= '0;
            frameValid_q <= 1'b0;
            frameErr_q   <= 1'b0;
            errCount_q   <= '0;
        end else if (!clk_half) begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            toCnt_q      <= toCnt_d;
            shadow_q     <= shadow_d;
            chOut_q      <= chOut_d;
            modeShadow_q <= modeShadow_d;
            modeOut_q    <= modeOut_d;
            frameValid_q <= frameValid_d;
            frameErr_q   <= frameErr_d;
            errCount_q   <= errCount_d;
        end
    end

    assign ch_out      = chOut_q;
    assign mode_out    = modeOut_q;
    assign frame_valid = frameValid_q;
    assign frame_err   = frameErr_q;
    assign err_count   = errCount_q;
    assign busy        = (state_q != ST_HUNT);

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_rgbw_frame_decoder
// Drives two decoder instances: dut0 with default parameters and dut1 with
// three channels, no checksum and a short timeout.
// ---------------------------------------------------------------------------
module tb_rgbw_frame_decoder;

    localparam int NCH0 = 6;
    localparam int TO0  = 4096;
    localparam int NCH1 = 3;
    localparam int TO1  = 8;

    logic clk      = 1'b0;
    logic clkHalf  = 1'b0;
    logic reset    = 1'b1;

    logic [7:0]        rxData0 = '0;
    logic              rxRdy0  = 1'b0;
    logic [NCH0*8-1:0] chOut0;
    logic [7:0]        modeOut0;
    logic              frameValid0, frameErr0, busy0;
    logic [7:0]        errCount0;

    logic [7:0]        rxData1 = '0;
    logic              rxRdy1  = 1'b0;
    logic [NCH1*8-1:0] chOut1;
    logic [7:0]        modeOut1;
    logic              frameValid1, frameErr1, busy1;
    logic [7:0]        errCount1;

    int errors = 0;
    int checks = 0;
    int validSeen0 = 0, errSeen0 = 0, validSeen1 = 0, errSeen1 = 0;

    // Clock and a clock enable that is low on every other clk rising edge.
    always #5 clk = ~clk;
    always #10 clkHalf = ~clkHalf;

    rgbw_frame_decoder #(
        .NUM_CH(NCH0), .DATA_W(8), .SYNC_BYTE(8'h55), .CHECKSUM_EN(1'b1), .TIMEOUT_CYC(TO0)
    ) dut0 (
        .clk(clk), .reset(reset), .clk_half(clkHalf), .rx_data(rxData0), .rx_rdy(rxRdy0),
        .ch_out(chOut0), .mode_out(modeOut0), .frame_valid(frameValid0),
        .frame_err(frameErr0), .err_count(errCount0), .busy(busy0)
    );

    rgbw_frame_decoder #(
        .NUM_CH(NCH1), .DATA_W(8), .SYNC_BYTE(8'h55), .CHECKSUM_EN(1'b0), .TIMEOUT_CYC(TO1)
    ) dut1 (
        .clk(clk), .reset(reset), .clk_half(clkHalf), .rx_data(rxData1), .rx_rdy(rxRdy1),
        .ch_out(chOut1), .mode_out(modeOut1), .frame_valid(frameValid1),
        .frame_err(frameErr1), .err_count(errCount1), .busy(busy1)
    );

    // Pulse counters, sampled once per enabled cycle just after the edge.
    always @(posedge clk) begin
        if (!clkHalf) begin
            #1;
            if (frameValid0) validSeen0++;
            if (frameErr0)   errSeen0++;
            if (frameValid1) validSeen1++;
            if (frameErr1)   errSeen1++;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    typedef struct packed {
        logic [0:15][7:0] bytes;
        logic [7:0]       nBytes;
        logic [7:0]       hold;
        logic [47:0]      expCh;
        logic [7:0]       expMode;
        logic             expValid;
        logic             expErr;
    } vec_t;

    vec_t vecs [5];

    task automatic waitEnabled(input int n);
        repeat (n) begin
            do @(posedge clk); while (clkHalf !== 1'b0);
        end
        #2;
    endtask

    // One byte: rx_rdy high for 'hi' enabled cycles, then low for 'lo'.
    task automatic applyStimulus(input int sel, input logic [7:0] b, input int hi, input int lo);
        if (sel == 0) begin rxData0 = b; rxRdy0 = 1'b1; end
        else          begin rxData1 = b; rxRdy1 = 1'b1; end
        waitEnabled(hi);
        if (sel == 0) rxRdy0 = 1'b0; else rxRdy1 = 1'b0;
        waitEnabled(lo);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    initial begin
        int vStart, eStart, waited;
        int errModel0;
        logic [NCH0-1:0][7:0] modelCh;
        logic [7:0] modelMode;
        logic [7:0] pl [NCH0];
        logic [7:0] md, cs, jb;
        int total;
        bit good;
        logic [47:0] keepCh;
        logic [7:0] keepMode;

        // Frame sum 10+03+FF+80+40+20+02 = 0x1F4, so 0x0C closes it to zero
        // and both 0x0F and 0x0E leave a residue.
        vecs[0] = '{bytes: {8'h55,8'h10,8'h03,8'hFF,8'h80,8'h40,8'h20,8'h02,8'h0C,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    nBytes: 8'd9, hold: 8'd3, expCh: 48'h2040_80FF_0310, expMode: 8'h02, expValid: 1'b1, expErr: 1'b0};
        vecs[1] = '{bytes: {8'h55,8'h10,8'h03,8'hFF,8'h80,8'h40,8'h20,8'h02,8'h0F,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    nBytes: 8'd9, hold: 8'd3, expCh: 48'h2040_80FF_0310, expMode: 8'h02, expValid: 1'b0, expErr: 1'b1};
        vecs[2] = '{bytes: {8'h55,8'h10,8'h03,8'hFF,8'h80,8'h40,8'h20,8'h02,8'h0E,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    nBytes: 8'd9, hold: 8'd3, expCh: 48'h2040_80FF_0310, expMode: 8'h02, expValid: 1'b0, expErr: 1'b1};
        vecs[3] = '{bytes: {8'h00,8'hAA,8'h13,8'h55,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'hE4,8'h00,8'h00,8'h00,8'h00},
                    nBytes: 8'd12, hold: 8'd3, expCh: 48'h0605_0403_0201, expMode: 8'h07, expValid: 1'b1, expErr: 1'b0};
        vecs[4] = '{bytes: {8'h55,8'h55,8'h55,8'h00,8'h01,8'hAA,8'hFE,8'h33,8'h7A,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    nBytes: 8'd9, hold: 8'd12, expCh: 48'hFEAA_0100_5555, expMode: 8'h33, expValid: 1'b1, expErr: 1'b0};

        // Reset state.
        waitEnabled(4);
        reset = 1'b0;
        waitEnabled(2);
        checkOutput("reset_ch0",    64'(chOut0), 64'h0);
        checkOutput("reset_mode0",  64'(modeOut0), 64'h0);
        checkOutput("reset_err0",   64'(errCount0), 64'h0);
        checkOutput("reset_busy0",  64'(busy0), 64'h0);
        checkOutput("reset_pulses", 64'(validSeen0 + errSeen0), 64'h0);
        errModel0 = 0;

        // Directed frame table.
        for (int v = 0; v < 5; v++) begin
            vStart = validSeen0;
            eStart = errSeen0;
            for (int k = 0; k < int'(vecs[v].nBytes); k++) begin
                applyStimulus(0, vecs[v].bytes[k], int'(vecs[v].hold), 3);
            end
            if (vecs[v].expErr) errModel0++;
            checkOutput($sformatf("vec%0d_ch", v),    64'(chOut0), 64'(vecs[v].expCh));
            checkOutput($sformatf("vec%0d_mode", v),  64'(modeOut0), 64'(vecs[v].expMode));
            checkOutput($sformatf("vec%0d_valid", v), 64'(validSeen0 - vStart), 64'(vecs[v].expValid));
            checkOutput($sformatf("vec%0d_err", v),   64'(errSeen0 - eStart), 64'(vecs[v].expErr));
            checkOutput($sformatf("vec%0d_errcnt", v), 64'(errCount0), 64'(errModel0));
            checkOutput($sformatf("vec%0d_busy", v),  64'(busy0), 64'h0);
        end

        // Timeout in the middle of a frame.
        keepCh   = chOut0;
        keepMode = modeOut0;
        eStart   = errSeen0;
        vStart   = validSeen0;
        applyStimulus(0, 8'h55, 3, 3);
        applyStimulus(0, 8'h10, 3, 3);
        applyStimulus(0, 8'h03, 3, 3);
        checkOutput("to0_busy_before", 64'(busy0), 64'h1);
        waited = 0;
        while (errSeen0 == eStart && waited < TO0 + 32) begin
            waitEnabled(1);
            waited++;
        end
        errModel0++;
        checkOutput("to0_fired",  64'(errSeen0 - eStart), 64'h1);
        checkOutput("to0_window", 64'(waited >= TO0 - 12 && waited <= TO0 + 4), 64'h1);
        checkOutput("to0_busy",   64'(busy0), 64'h0);
        checkOutput("to0_ch",     64'(chOut0), 64'(keepCh));
        checkOutput("to0_mode",   64'(modeOut0), 64'(keepMode));
        checkOutput("to0_valid",  64'(validSeen0 - vStart), 64'h0);
        checkOutput("to0_errcnt", 64'(errCount0), 64'(errModel0));
        for (int k = 0; k < 9; k++) applyStimulus(0, vecs[3].bytes[k + 3], 3, 3);
        checkOutput("to0_next_ch", 64'(chOut0), 64'(vecs[3].expCh));

        // Randomized frames against a sum-to-zero reference model.
        modelCh   = chOut0;
        modelMode = modeOut0;
        for (int f = 0; f < 40; f++) begin
            vStart = validSeen0;
            eStart = errSeen0;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'h55) jb = 8'h56;
                applyStimulus(0, jb, $urandom_range(3, 6), $urandom_range(3, 5));
            end
            total = 0;
            for (int c = 0; c < NCH0; c++) begin
                pl[c] = 8'($urandom_range(0, 255));
                total += int'(pl[c]);
            end
            md = 8'($urandom_range(0, 255));
            total += int'(md);
            good = ($urandom_range(0, 3) != 0);
            cs = 8'((256 - (total % 256)) % 256);
            if (!good) cs = 8'((int'(cs) + $urandom_range(1, 255)) % 256);
            applyStimulus(0, 8'h55, $urandom_range(3, 6), $urandom_range(3, 5));
            for (int c = 0; c < NCH0; c++) applyStimulus(0, pl[c], $urandom_range(3, 6), $urandom_range(3, 5));
            applyStimulus(0, md, $urandom_range(3, 6), $urandom_range(3, 5));
            applyStimulus(0, cs, $urandom_range(3, 6), 3);
            if (good) begin
                for (int c = 0; c < NCH0; c++) modelCh[c] = pl[c];
                modelMode = md;
            end else begin
                errModel0++;
            end
            checkOutput($sformatf("rnd%0d_ch", f),     64'(chOut0), 64'(modelCh));
            checkOutput($sformatf("rnd%0d_mode", f),   64'(modeOut0), 64'(modelMode));
            checkOutput($sformatf("rnd%0d_valid", f),  64'(validSeen0 - vStart), 64'(good ? 1 : 0));
            checkOutput($sformatf("rnd%0d_err", f),    64'(errSeen0 - eStart), 64'(good ? 0 : 1));
            checkOutput($sformatf("rnd%0d_errcnt", f), 64'(errCount0), 64'(errModel0));
        end

        // Reset four bytes into a frame, on an edge where the enable is high.
        for (int k = 0; k < 4; k++) applyStimulus(0, vecs[0].bytes[k], 3, 3);
        checkOutput("rst_busy_before", 64'(busy0), 64'h1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("rst_edge_disabled", 64'(clkHalf), 64'h1);
        checkOutput("rst_ch",     64'(chOut0), 64'h0);
        checkOutput("rst_mode",   64'(modeOut0), 64'h0);
        checkOutput("rst_errcnt", 64'(errCount0), 64'h0);
        checkOutput("rst_busy",   64'(busy0), 64'h0);
        reset = 1'b0;
        waitEnabled(2);
        vStart = validSeen0;
        for (int k = 0; k < 9; k++) applyStimulus(0, vecs[0].bytes[k], 3, 3);
        checkOutput("rst_next_ch",    64'(chOut0), 64'(vecs[0].expCh));
        checkOutput("rst_next_mode",  64'(modeOut0), 64'(vecs[0].expMode));
        checkOutput("rst_next_valid", 64'(validSeen0 - vStart), 64'h1);

        // Three channels, no checksum byte.
        vStart = validSeen1;
        applyStimulus(1, 8'h55, 3, 3);
        applyStimulus(1, 8'h01, 3, 3);
        applyStimulus(1, 8'h02, 3, 3);
        applyStimulus(1, 8'h03, 3, 3);
        applyStimulus(1, 8'h04, 3, 3);
        checkOutput("nc_ch",    64'(chOut1), 64'h03_0201);
        checkOutput("nc_mode",  64'(modeOut1), 64'h04);
        checkOutput("nc_valid", 64'(validSeen1 - vStart), 64'h1);
        checkOutput("nc_busy",  64'(busy1), 64'h0);

        // Repeated timeouts drive the error counter into saturation.
        for (int t = 0; t < 300; t++) begin
            eStart = errSeen1;
            applyStimulus(1, 8'h55, 3, 3);
            waited = 0;
            while (errSeen1 == eStart && waited < TO1 + 16) begin
                waitEnabled(1);
                waited++;
            end
            checkOutput($sformatf("sat_to%0d", t), 64'(errSeen1 - eStart), 64'h1);
            if (t == 99) checkOutput("sat_cnt100", 64'(errCount1), 64'd100);
        end
        checkOutput("sat_cnt",  64'(errCount1), 64'd255);
        checkOutput("sat_ch",   64'(chOut1), 64'h03_0201);
        checkOutput("sat_mode", 64'(modeOut1), 64'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
